bytecode_sequencer: RTL and testbench

BYTECODE_SEQUENCER -- requirements
Module: bytecode_sequencer

---
 rtl/bytecode_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_bytecode_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_sequencer.sv
// Fetch/decode/pop/execute sequencer for a byte-coded stack machine.
// Optional stack-underflow trap: define BALI_UNDERFLOW_CHECK_EN.
module bytecode_sequencer #(
   parameter int unsigned PC_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                instr_done,
   output logic                fault,
   output logic [PC_WIDTH-1:0] mem_addr,
   output logic                mem_req,
   input  logic                mem_rdy,
   input  logic [7:0]          mem_data,
   output logic [7:0]          dec_opcode,
   input  logic                dec_isaluop,
   input  logic                dec_isgoto,
   input  logic                dec_isargpush,
   input  logic                dec_isconstpush,
   input  logic [31:0]         dec_constval,
   input  logic [1:0]          dec_argc,
   input  logic [1:0]          dec_stackargs,
   input  logic                dec_stackwb,
   output logic                stk_pop,
   input  logic [31:0]         stk_rdata,
   input  logic                stk_empty,
   output logic                stk_push,
   output logic [31:0]         stk_wdata,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   input  logic [31:0]         alu_result
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ARGS, S_POP, S_EXEC
`ifdef BALI_UNDERFLOW_CHECK_EN
      , S_FAULT
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d, ipc_q, ipc_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [15:0]         argbuf_q, argbuf_d;
   logic [1:0]          argc_q, argc_d, argcnt_q, argcnt_d;
   logic [1:0]          nargs_q, nargs_d, popcnt_q, popcnt_d;
   logic                isalu_q, isalu_d, isgoto_q, isgoto_d;
   logic                isarg_q, isarg_d, isconst_q, isconst_d, wb_q, wb_d;
   logic [31:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic                underflow;

`ifdef BALI_UNDERFLOW_CHECK_EN
   logic fault_q, fault_d;
   assign underflow = stk_empty;
   assign fault     = fault_q;
`else
   logic unused_stk_empty;
   assign unused_stk_empty = stk_empty;
   assign underflow        = 1'b0;
   assign fault            = 1'b0;
`endif

   assign mem_addr   = pc_q;
   assign dec_opcode = opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ipc_d      = ipc_q;
      opcode_d   = opcode_q;
      argbuf_d   = argbuf_q;
      argc_d     = argc_q;
      argcnt_d   = argcnt_q;
      nargs_d    = nargs_q;
      popcnt_d   = popcnt_q;
      isalu_d    = isalu_q;
      isgoto_d   = isgoto_q;
      isarg_d    = isarg_q;
      isconst_d  = isconst_q;
      wb_d       = wb_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
`ifdef BALI_UNDERFLOW_CHECK_EN
      fault_d    = fault_q;
`endif
      mem_req    = 1'b0;
      stk_pop    = 1'b0;
      stk_push   = 1'b0;
      stk_wdata  = '0;
      instr_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               opcode_d = mem_data;
               ipc_d    = pc_q;
               pc_d     = pc_q + PC_WIDTH'(1);
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            argc_d    = dec_argc;
            argcnt_d  = dec_argc;
            nargs_d   = dec_stackargs;
            popcnt_d  = '0;
            argbuf_d  = '0;
            isalu_d   = dec_isaluop;
            isgoto_d  = dec_isgoto;
            isarg_d   = dec_isargpush;
            isconst_d = dec_isconstpush;
            wb_d      = dec_stackwb;
            if (dec_argc != 2'd0)           state_d = S_ARGS;
            else if (dec_stackargs != 2'd0) state_d = S_POP;
            else                            state_d = S_EXEC;
         end
         S_ARGS: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               argbuf_d = {argbuf_q[7:0], mem_data};
               pc_d     = pc_q + PC_WIDTH'(1);
               argcnt_d = argcnt_q - 2'd1;
               if (argcnt_q == 2'd1) state_d = (nargs_q != 2'd0) ? S_POP : S_EXEC;
            end
         end
         S_POP: begin
            if (underflow) begin
`ifdef BALI_UNDERFLOW_CHECK_EN
               state_d = S_FAULT;
               fault_d = 1'b1;
`endif
            end else begin
               // Second pop shifts the earlier top-of-stack into alu_a.
               stk_pop  = 1'b1;
               alu_b_d  = stk_rdata;
               if (popcnt_q != 2'd0) alu_a_d = alu_b_q;
               popcnt_d = popcnt_q + 2'd1;
               if (popcnt_q + 2'd1 == nargs_q) state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
            if (wb_q) begin
               stk_push = 1'b1;
               if (isalu_q)        stk_wdata = alu_result;
               else if (isconst_q) stk_wdata = dec_constval;
               else if (isarg_q)   stk_wdata = (argc_q == 2'd1) ? 32'($signed(argbuf_q[7:0]))
                                                                : 32'($signed(argbuf_q));
            end
            if (isgoto_q) pc_d = ipc_q + PC_WIDTH'($signed(argbuf_q));
         end
`ifdef BALI_UNDERFLOW_CHECK_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ipc_q     <= '0;
         opcode_q  <= '0;
         argbuf_q  <= '0;
         argc_q    <= '0;
         argcnt_q  <= '0;
         nargs_q   <= '0;
         popcnt_q  <= '0;
         isalu_q   <= 1'b0;
         isgoto_q  <= 1'b0;
         isarg_q   <= 1'b0;
         isconst_q <= 1'b0;
         wb_q      <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
`ifdef BALI_UNDERFLOW_CHECK_EN
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ipc_q     <= ipc_d;
         opcode_q  <= opcode_d;
         argbuf_q  <= argbuf_d;
         argc_q    <= argc_d;
         argcnt_q  <= argcnt_d;
         nargs_q   <= nargs_d;
         popcnt_q  <= popcnt_d;
         isalu_q   <= isalu_d;
         isgoto_q  <= isgoto_d;
         isarg_q   <= isarg_d;
         isconst_q <= isconst_d;
         wb_q      <= wb_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
`ifdef BALI_UNDERFLOW_CHECK_EN
         fault_q   <= fault_d;
`endif
      end
   end

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Scoreboard bench for bytecode_sequencer: memory, stack, decoder and ALU models around the DUT.
`timescale 1ns/1ps
module tb_bytecode_sequencer;

   logic        clk, rst_n, start;
   logic        instr_done, fault, mem_req, mem_rdy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data, dec_opcode;
   logic        dec_isaluop, dec_isgoto, dec_isargpush, dec_isconstpush, dec_stackwb;
   logic [31:0] dec_constval;
   logic [1:0]  dec_argc, dec_stackargs;
   logic        stk_pop, stk_empty, stk_push;
   logic [31:0] stk_rdata, stk_wdata, alu_a, alu_b, alu_result;

   bytecode_sequencer #(.PC_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr_done(instr_done), .fault(fault),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdy(mem_rdy), .mem_data(mem_data),
      .dec_opcode(dec_opcode), .dec_isaluop(dec_isaluop), .dec_isgoto(dec_isgoto),
      .dec_isargpush(dec_isargpush), .dec_isconstpush(dec_isconstpush),
      .dec_constval(dec_constval), .dec_argc(dec_argc), .dec_stackargs(dec_stackargs),
      .dec_stackwb(dec_stackwb), .stk_pop(stk_pop), .stk_rdata(stk_rdata),
      .stk_empty(stk_empty), .stk_push(stk_push), .stk_wdata(stk_wdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
   );

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mem [0:255];
   logic [31:0] stk[$];
   logic [31:0] exp_push[$];
   logic [15:0] exp_addr[$];
   int          mem_delay = 0;
   int          pop_cnt = 0;
   int          done_cnt = 0;
   logic        pop_pend = 1'b0;
   logic        push_pend = 1'b0;
   logic [31:0] push_val = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Small opcode table: iconst_1/2, bipush, sipush, pop, iadd, goto; anything else is a nop.
   always_comb begin
      dec_isaluop = 1'b0; dec_isgoto = 1'b0; dec_isargpush = 1'b0; dec_isconstpush = 1'b0;
      dec_constval = '0; dec_argc = 2'd0; dec_stackargs = 2'd0; dec_stackwb = 1'b0;
      case (dec_opcode)
         8'h04: begin dec_isconstpush = 1'b1; dec_constval = 32'd1; dec_stackwb = 1'b1; end
         8'h05: begin dec_isconstpush = 1'b1; dec_constval = 32'd2; dec_stackwb = 1'b1; end
         8'h10: begin dec_isargpush = 1'b1; dec_argc = 2'd1; dec_stackwb = 1'b1; end
         8'h11: begin dec_isargpush = 1'b1; dec_argc = 2'd2; dec_stackwb = 1'b1; end
         8'h57: dec_stackargs = 2'd1;
         8'h60: begin dec_isaluop = 1'b1; dec_stackargs = 2'd2; dec_stackwb = 1'b1; end
         8'hA7: begin dec_isgoto = 1'b1; dec_argc = 2'd2; end
         default: ;
      endcase
   end

   assign alu_result = alu_a + alu_b;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Environment: memory responder and stack update, both just after the rising edge.
   initial begin
      int cnt;
      cnt = 0;
      mem_rdy = 1'b0; mem_data = '0; stk_rdata = '0; stk_empty = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (pop_pend && stk.size() != 0) void'(stk.pop_back());
            if (push_pend) stk.push_back(push_val);
         end
         pop_pend = 1'b0;
         push_pend = 1'b0;
         stk_empty = (stk.size() == 0);
         stk_rdata = (stk.size() != 0) ? stk[stk.size()-1] : 32'd0;
         if (mem_req) begin
            if (cnt >= mem_delay) begin
               mem_rdy = 1'b1; mem_data = mem[mem_addr[7:0]]; cnt = 0;
            end else begin
               mem_rdy = 1'b0; cnt++;
            end
         end else begin
            mem_rdy = 1'b0; cnt = 0;
         end
      end
   end

   // Monitor: compares every push and completed fetch against the scoreboard queues.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (stk_pop || stk_push) check("pop_push_exclusive", {31'b0, stk_pop & stk_push}, 32'd0);
            if (stk_push) begin
               if (exp_push.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_push: got 0x%08h expected no push", stk_wdata);
               end else begin
                  e = exp_push.pop_front();
                  check("push_data", stk_wdata, e);
               end
               push_pend = 1'b1;
               push_val  = stk_wdata;
            end
            if (stk_pop) begin pop_cnt++; pop_pend = 1'b1; end
            if (instr_done) done_cnt++;
            if (mem_req && mem_rdy && exp_addr.size() != 0)
               check("fetch_addr", {16'b0, mem_addr}, {16'b0, exp_addr.pop_front()});
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);
      stk.delete(); exp_push.delete(); exp_addr.delete();
      pop_cnt = 0; done_cnt = 0; mem_delay = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int n, input string name);
      int k;
      k = 0;
      while (done_cnt < n && k < 200) begin @(posedge clk); k++; end
      check(name, done_cnt, n);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_instr_done"}, {31'b0, instr_done}, 32'd0);
      check({pfx, "_fault"}, {31'b0, fault}, 32'd0);
      check({pfx, "_mem_req"}, {31'b0, mem_req}, 32'd0);
      check({pfx, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
      check({pfx, "_dec_opcode"}, {24'b0, dec_opcode}, 32'd0);
      check({pfx, "_stk_pop"}, {31'b0, stk_pop}, 32'd0);
      check({pfx, "_stk_push"}, {31'b0, stk_push}, 32'd0);
      check({pfx, "_stk_wdata"}, stk_wdata, 32'd0);
      check({pfx, "_alu_a"}, alu_a, 32'd0);
      check({pfx, "_alu_b"}, alu_b, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, req_cycles;
      logic stable;
      rst_n = 1'b0; start = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset state
      do_reset();
      @(negedge clk); #1;
      check_zero("reset");

      // iconst_1, iconst_2, iadd
      do_reset();
      mem[0] = 8'h04; mem[1] = 8'h05; mem[2] = 8'h60;
      exp_addr = '{16'd0, 16'd1, 16'd2};
      exp_push = '{32'd1, 32'd2, 32'd3};
      pulse_start();
      wait_done(3, "iadd_retire_count");
      @(negedge clk); #1;
      check("iadd_pop_count", pop_cnt, 2);
      check("iadd_stack_depth", stk.size(), 1);
      check("iadd_stack_top", (stk.size() != 0) ? stk[0] : 32'hDEAD_BEEF, 32'd3);
      check("iadd_next_addr", {16'b0, mem_addr}, 32'd3);
      check("iadd_push_drained", exp_push.size(), 0);

      // bipush 0xFE, sipush 0x8001
      do_reset();
      mem[0] = 8'h10; mem[1] = 8'hFE; mem[2] = 8'h11; mem[3] = 8'h80; mem[4] = 8'h01;
      exp_addr = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
      exp_push = '{32'hFFFF_FFFE, 32'hFFFF_8001};
      pulse_start();
      wait_done(1, "bipush_retire");
      @(negedge clk); #1;
      check("bipush_pc", {16'b0, mem_addr}, 32'd2);
      wait_done(2, "sipush_retire");
      @(negedge clk); #1;
      check("sipush_pc", {16'b0, mem_addr}, 32'd5);

      // goto -3 at address 5
      do_reset();
      mem[5] = 8'hA7; mem[6] = 8'hFF; mem[7] = 8'hFD;
      exp_addr = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd2, 16'd3};
      pulse_start();
      wait_done(6, "goto_retire");
      @(negedge clk); #1;
      check("goto_target", {16'b0, mem_addr}, 32'd2);
      check("goto_no_push", pop_cnt, 0);

      // Slow memory: three wait cycles
      do_reset();
      mem_delay = 3;
      mem[0] = 8'h04;
      exp_addr = '{16'd0};
      exp_push = '{32'd1};
      pulse_start();
      k = 0;
      while (!mem_req && k < 20) begin @(negedge clk); #1; k++; end
      req_cycles = 0; stable = 1'b1;
      while (mem_req && req_cycles < 20) begin
         if (mem_addr !== 16'd0) stable = 1'b0;
         req_cycles++;
         @(negedge clk); #1;
      end
      check("slow_req_cycles", req_cycles, 4);
      check("slow_addr_stable", {31'b0, stable}, 32'd1);
      wait_done(1, "slow_retire");
      @(negedge clk); #1;
      check("slow_single_inc", {16'b0, mem_addr}, 32'd1);

      // Reset during ARGS, then restart from address 0
      do_reset();
      mem_delay = 2;
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
      exp_addr = '{16'd0};
      pulse_start();
      k = 0;
      while (!(mem_req && mem_addr == 16'd1) && k < 40) begin @(negedge clk); #1; k++; end
      check("args_reached", {31'b0, mem_req && mem_addr == 16'd1}, 32'd1);
      check("args_opcode", {24'b0, dec_opcode}, 32'h11);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      do_reset();
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
      exp_addr = '{16'd0, 16'd1, 16'd2};
      exp_push = '{32'h0000_1234};
      pulse_start();
      wait_done(1, "restart_retire");
      @(negedge clk); #1;
      check("restart_pc", {16'b0, mem_addr}, 32'd3);

      // iadd on an empty stack
      do_reset();
      mem[0] = 8'h60;
      exp_addr = '{16'd0};
`ifdef BALI_UNDERFLOW_CHECK_EN
      pulse_start();
      k = 0;
      while (!fault && k < 50) begin @(negedge clk); #1; k++; end
      check("underflow_fault", {31'b0, fault}, 32'd1);
      req_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (mem_req) req_cycles++;
      end
      check("underflow_no_req", req_cycles, 0);
      check("underflow_no_pop", pop_cnt, 0);
      check("underflow_no_retire", done_cnt, 0);
      check("underflow_fault_sticky", {31'b0, fault}, 32'd1);
`else
      exp_push = '{32'd0};
      pulse_start();
      wait_done(1, "empty_iadd_retire");
      @(negedge clk); #1;
      check("empty_iadd_pops", pop_cnt, 2);
      check("empty_iadd_fault", {31'b0, fault}, 32'd0);
      check("empty_iadd_push_drained", exp_push.size(), 0);
`endif

      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
